// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button conditioner.
//   db_state_t : one-hot state of a single debounce channel.
//     ZERO  - button settled released
//     WAIT1 - candidate press, counting stable high samples
//     ONE   - button settled pressed
//     WAIT0 - candidate release, counting stable low samples
// ---------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'b0001,
    WAIT1 = 4'b0010,
    ONE   = 4'b0100,
    WAIT0 = 4'b1000
  } db_state_t;

endpackage : btn_pkg

// File: rtl/debounce_fsm.sv
// ---------------------------------------------------------------------------
// debounce_fsm
// One button channel: synchronizer chain, one-hot debounce FSM and a
// stable-sample counter. All outputs are registered.
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   raw_i     - asynchronous, bouncing button input (active high)
//   level_o   - debounced level (1 in ONE or WAIT0)
//   press_o   - one-cycle pulse after the WAIT1->ONE edge
//   release_o - one-cycle pulse after the WAIT0->ZERO edge
// ---------------------------------------------------------------------------
module debounce_fsm
  import btn_pkg::*;
#(
  parameter int DB_TICKS    = 2_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CW = $clog2(DB_TICKS + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  // Last count value; reaching it with a stable sample commits the new level,
  // so the counter never needs to go further and cannot wrap.
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  db_state_t              state_q;
  logic [CW-1:0]          cnt_q;
  logic                   level_q;
  logic                   press_q;
  logic                   release_q;

  // Metastability chain: raw input shifts towards the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Debounce FSM with counter and registered level/pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ZERO;
      cnt_q     <= CNT_ZERO;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        ZERO: begin
          if (sync_s) begin
            state_q <= WAIT1;
            cnt_q   <= CNT_ZERO;
          end
        end
        WAIT1: begin
          if (!sync_s) begin
            state_q <= ZERO;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ONE;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ONE: begin
          if (!sync_s) begin
            state_q <= WAIT0;
            cnt_q   <= CNT_ZERO;
          end
        end
        WAIT0: begin
          if (sync_s) begin
            state_q <= ONE;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= ZERO;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          // Corrupted one-hot encoding: recover silently to released.
          state_q <= ZERO;
          cnt_q   <= CNT_ZERO;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule : debounce_fsm

// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
// N_BTN independent push-button conditioners (synchronize, debounce,
// edge-detect). Channels share only clock and reset.
// Ports:
//   clk         - rising-edge clock
//   rst_n       - asynchronous active-low reset
//   btn_raw     - asynchronous bouncing buttons, active high
//   btn_level   - debounced levels
//   btn_press   - one-cycle pulse per debounced press
//   btn_release - one-cycle pulse per debounced release
// ---------------------------------------------------------------------------
module btn_conditioner #(
  parameter int N_BTN       = 3,
  parameter int DB_TICKS    = 2_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    debounce_fsm #(
      .DB_TICKS    (DB_TICKS),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_db (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw_i     (btn_raw[g]),
      .level_o   (btn_level[g]),
      .press_o   (btn_press[g]),
      .release_o (btn_release[g])
    );
  end

endmodule : btn_conditioner

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with DB_TICKS=4, SYNC_STAGES=2, N_BTN=3.
// A reference model pushes the expected outputs of every clock edge into a
// queue; a monitor on the falling edge pops and compares.
module tb_btn_conditioner;

  localparam int N  = 3;
  localparam int DB = 4;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rls;
  } exp_t;

  exp_t         exp_q[$];
  logic [N-1:0] raw_hist[$];
  logic [N-1:0] m_level;
  int           m_run[N];

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN       (N),
    .DB_TICKS    (DB),
    .SYNC_STAGES (SS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  // Reference model: an input value seen SS edges ago is the debouncer's view;
  // the level flips once DB+1 consecutive views disagree with it.
  always @(posedge clk) begin
    exp_t         e;
    logic [N-1:0] s;
    e = '0;
    if (!rst_n) begin
      raw_hist.delete();
      m_level = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      raw_hist.push_back(btn_raw);
      s = '0;
      if (raw_hist.size() > SS) s = raw_hist.pop_front();
      for (int i = 0; i < N; i++) begin
        if (s[i] != m_level[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DB + 1) begin
            m_level[i] = s[i];
            m_run[i]   = 0;
            if (s[i]) e.prs[i] = 1'b1;
            else      e.rls[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    e.lvl = m_level;
    exp_q.push_back(e);
  end

  // Monitor: compare DUT outputs with the oldest expectation every cycle.
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      if ({btn_level, btn_press, btn_release} !== e) begin
        failures++;
        $display("FAIL outputs at %0t: level=%b press=%b release=%b expected level=%b press=%b release=%b",
                 $time, btn_level, btn_press, btn_release, e.lvl, e.prs, e.rls);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Counts rising edges (first one = 1) until the selected pulse appears.
  task automatic expect_latency(input int ch, input bit rel, input string name);
    int found = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if ((rel ? btn_release[ch] : btn_press[ch]) && found == 0) found = k;
    end
    checks++;
    if (found != SS + DB + 1) begin
      failures++;
      $display("FAIL %s latency: got edge %0d, expected edge %0d", name, found, SS + DB + 1);
    end
    tick(1);
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_raw = '0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Clean press on channel 0.
    btn_raw[0] = 1'b1;
    expect_latency(0, 1'b0, "clean_press");
    tick(5);

    // Bounce on channel 1 then settle high.
    btn_raw[1] = 1'b1; tick(1);
    btn_raw[1] = 1'b0; tick(1);
    btn_raw[1] = 1'b1; tick(1);
    btn_raw[1] = 1'b0; tick(1);
    btn_raw[1] = 1'b1;
    expect_latency(1, 1'b0, "bounce_press");

    // Short glitch on channel 2.
    btn_raw[2] = 1'b1; tick(3);
    btn_raw[2] = 1'b0; tick(15);

    // Release of channel 0.
    btn_raw[0] = 1'b0;
    expect_latency(0, 1'b1, "release");

    // Simultaneous press of all channels.
    btn_raw = '0; tick(15);
    btn_raw = 3'b111;
    expect_latency(2, 1'b0, "simultaneous_press");
    btn_raw = '0; tick(15);

    // Reset while channel 0 is counting in WAIT1 (count 2).
    btn_raw[0] = 1'b1;
    tick(5);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    expect_latency(0, 1'b0, "press_after_reset");
    btn_raw = '0; tick(15);

    // Random activity, occasional resets.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) btn_raw[i] = ~btn_raw[i];
      rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    rst_n = 1'b1;
    tick(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_btn_conditioner

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter N_BTN, default 3; number of independent button channels.
REQ-002 SHALL have parameter DB_TICKS, default 2_000_000; stable-sample count (20 ms at 100 MHz); legal range >= 1.
REQ-003 SHALL have parameter SYNC_STAGES, default 2; synchronizer depth; legal range >= 2.
REQ-004 SHALL have port clk, input, 1 bit; single clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit; asynchronous, active-low reset.
REQ-006 SHALL have port btn_raw, input, N_BTN bits; asynchronous, bouncing push-button inputs, active-high.
REQ-007 SHALL have port btn_level, output, N_BTN bits; debounced button level.
REQ-008 SHALL have port btn_press, output, N_BTN bits; one-cycle pulse on each debounced press; drives start/stop/clear of the reaction-timer FSM.
REQ-009 SHALL have port btn_release, output, N_BTN bits; one-cycle pulse on each debounced release.

Function
REQ-010 SHALL pass each btn_raw bit through a SYNC_STAGES-deep flip-flop chain before any other use; the last stage is "sync".
REQ-011 SHALL run one independent FSM per channel with one-hot states ZERO, WAIT1, ONE, WAIT0, plus a counter of width $clog2(DB_TICKS+1).
REQ-012 In ZERO: on sync=1 SHALL go to WAIT1 and clear the counter; otherwise SHALL stay.
REQ-013 In WAIT1: on sync=0 SHALL return to ZERO; on sync=1 with counter = DB_TICKS-1 SHALL go to ONE; otherwise SHALL increment the counter.
REQ-014 In ONE: on sync=0 SHALL go to WAIT0 and clear the counter; otherwise SHALL stay.
REQ-015 In WAIT0: on sync=1 SHALL return to ONE; on sync=0 with counter = DB_TICKS-1 SHALL go to ZERO; otherwise SHALL increment the counter.
REQ-016 An unreachable state encoding SHALL go to ZERO on the next edge, with no pulse asserted.
REQ-017 btn_level SHALL be 1 exactly when the state is ONE or WAIT0.
REQ-018 btn_press SHALL be registered and asserted for exactly the one cycle following the WAIT1->ONE edge.
REQ-019 btn_release SHALL be registered and asserted for exactly the one cycle following the WAIT0->ZERO edge.
REQ-020 Latency: with btn_raw held high and the first sampling edge numbered 1, btn_press SHALL rise on edge SYNC_STAGES+DB_TICKS+1; release latency SHALL be symmetric.
REQ-021 A high or low glitch shorter than DB_TICKS sync cycles SHALL produce no pulse and no btn_level change.
REQ-022 Simultaneous activity on several channels SHALL be handled independently, with no cross-channel effect.
REQ-023 btn_press and btn_release of one channel SHALL never be asserted in the same cycle.
REQ-024 The counter SHALL never wrap; it saturates by construction at DB_TICKS-1.

Reset
REQ-025 On rst_n=0, all synchronizer flops, counters, btn_level, btn_press and btn_release SHALL clear to 0 immediately, and every FSM SHALL enter ZERO.
REQ-026 Reset asserted mid-WAIT1 or mid-WAIT0 SHALL abort the count with no pulse.
REQ-027 A button held through reset release SHALL produce btn_press after the full REQ-020 latency.

Structure
REQ-028 The one-hot state typedef db_state_t (4 bits: ZERO=0001, WAIT1=0010, ONE=0100, WAIT0=1000) SHALL live in shared package btn_pkg.
REQ-029 The single-channel synchronizer, FSM and counter SHALL be sub-module debounce_fsm, instantiated N_BTN times via generate.

Verification (DB_TICKS=4, SYNC_STAGES=2)
REQ-030 Clean press: btn_raw[0] 0->1 held -> btn_press[0] high on edge 7 only; btn_level[0]=1 from edge 7.
REQ-031 Bounce: btn_raw[1] toggles 1,0,1,0 each cycle, then holds 1 -> exactly one btn_press[1] pulse, 7 edges after the final rising sample.
REQ-032 Short glitch: btn_raw[2] high for 3 cycles -> no btn_press, btn_level[2] stays 0.
REQ-033 Release: held button dropped to 0 -> single btn_release pulse 7 edges later; btn_level falls on the same edge.
REQ-034 Simultaneous: all three buttons pressed on the same edge -> btn_press = 3'b111 for exactly one cycle.
REQ-035 Reset mid-WAIT1: rst_n low 1 cycle at count 2 -> no pulse; with button still held, btn_press fires 7 edges after reset release.
